// File: rtl/ctrl_pkg.sv
// Shared types for the decode queue: the registered control bundle, RV32I opcodes
// and the immediate-format selector codes consumed by the execute stage.
package ctrl_pkg;

    typedef struct packed {
        logic       Branch;
        logic       jumpSrc;
        logic       jalrSrc;
        logic [1:0] resultSrc;
        logic       memWrite;
        logic       aluSrc;
        logic       aluSrcA_pc;
        logic [2:0] immSrc;
        logic       regWrite;
        logic [1:0] aluOp;
        logic [2:0] sizeSrc;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

endpackage

// File: rtl/ctrl_decode_comb.sv
// Pure combinational main decoder: opcode/funct3 -> control bundle.
// Any illegal encoding collapses the bundle to all-zero with only the illegal flag set.
module ctrl_decode_comb
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output ctrl_t      ctrl_o
);

    logic bad;

    always_comb begin
        ctrl_o = '0;
        bad    = 1'b0;
        unique case (opcode_i)
            OPC_JAL: begin
                ctrl_o.regWrite  = 1'b1;
                ctrl_o.aluSrc    = 1'b1;
                ctrl_o.immSrc    = IMM_J;
                ctrl_o.resultSrc = 2'b10;
                ctrl_o.jumpSrc   = 1'b1;
            end
            OPC_JALR: begin
                ctrl_o.regWrite  = 1'b1;
                ctrl_o.aluSrc    = 1'b1;
                ctrl_o.immSrc    = IMM_I;
                ctrl_o.resultSrc = 2'b10;
                ctrl_o.jumpSrc   = 1'b1;
                ctrl_o.jalrSrc   = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_o.Branch = 1'b1;
                ctrl_o.immSrc = IMM_B;
                ctrl_o.aluOp  = 2'b01;
            end
            OPC_LOAD: begin
                ctrl_o.regWrite  = 1'b1;
                ctrl_o.aluSrc    = 1'b1;
                ctrl_o.immSrc    = IMM_I;
                ctrl_o.resultSrc = 2'b01;
                ctrl_o.sizeSrc   = funct3_i;
                // lb/lh/lw/lbu/lhu only
                bad = !(funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OPC_STORE: begin
                ctrl_o.memWrite = 1'b1;
                ctrl_o.aluSrc   = 1'b1;
                ctrl_o.immSrc   = IMM_S;
                ctrl_o.sizeSrc  = funct3_i;
                bad = (funct3_i > 3'b010);
            end
            OPC_OPIMM: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.aluSrc   = 1'b1;
                ctrl_o.immSrc   = IMM_I;
                ctrl_o.aluOp    = 2'b10;
            end
            OPC_OP: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.aluOp    = 2'b10;
            end
            OPC_LUI: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.aluSrc   = 1'b1;
                ctrl_o.immSrc   = IMM_U;
                ctrl_o.aluOp    = 2'b11;
            end
            OPC_AUIPC: begin
                ctrl_o.regWrite   = 1'b1;
                ctrl_o.aluSrc     = 1'b1;
                ctrl_o.aluSrcA_pc = 1'b1;
                ctrl_o.immSrc     = IMM_U;
                ctrl_o.aluOp      = 2'b00;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            ctrl_o         = '0;
            ctrl_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_ctrl_queue.sv
// Buffered decoder: decodes accepted instructions and queues control + operand fields
// in a DEPTH-entry FIFO toward execute; counts illegal instructions, supports flush.
module decode_ctrl_queue
    import ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [ADDR_W-1:0] pc,
    output logic              out_valid,
    input  logic              out_ready,
    output ctrl_t             out_ctrl,
    output logic [ADDR_W-1:0] out_pc,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [2:0]        out_funct3,
    output logic [CNT_W-1:0]  illegal_cnt
);

    // Handshake: a beat transfers on any rising edge where valid && ready are both high;
    // valid never depends on ready, and ready is withdrawn for the whole flush cycle.

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_B   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = $bits(ctrl_t) + ADDR_W + 18;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_B-1:0] FULL_CNT = CNT_B'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_B-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   illegal_cnt_q, illegal_cnt_d;
    ctrl_t              dec_ctrl;
    logic               push, pop;
    logic               unused_instr_bits;

    ctrl_decode_comb u_decode (
        .opcode_i (instr[6:0]),
        .funct3_i (instr[14:12]),
        .ctrl_o   (dec_ctrl)
    );

    assign unused_instr_bits = ^instr[31:25];

    assign in_ready  = (count_q != FULL_CNT) && !flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    assign {out_ctrl, out_pc, out_rd, out_rs1, out_rs2, out_funct3} = mem_q[rd_ptr_q];
    assign illegal_cnt = illegal_cnt_q;

    always_comb begin
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        illegal_cnt_d = illegal_cnt_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            // explicit wrap keeps non-power-of-two depths correct
            if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            if (push && !pop) count_d = count_q + 1'b1;
            if (pop && !push) count_d = count_q - 1'b1;
            if (push && dec_ctrl.illegal && (illegal_cnt_q != '1))
                illegal_cnt_d = illegal_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            illegal_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            illegal_cnt_q <= illegal_cnt_d;
            if (push) mem_q[wr_ptr_q] <= {dec_ctrl, pc, instr[11:7], instr[19:15], instr[24:20], instr[14:12]};
        end
    end

endmodule

// File: tb/tb_decode_ctrl_queue.sv
// Bench for decode_ctrl_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the decoder/FIFO/counter.
module tb_decode_ctrl_queue;
    import ctrl_pkg::*;

    localparam int DEPTH = 2;
    localparam int EW    = $bits(ctrl_t) + 32 + 18;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic        in_ready, out_valid;
    ctrl_t       out_ctrl;
    logic [31:0] out_pc;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [2:0]  out_funct3;
    logic [7:0]  illegal_cnt;
    logic        in_ready_s, out_valid_s;
    ctrl_t       out_ctrl_s;
    logic [31:0] out_pc_s;
    logic [4:0]  out_rd_s, out_rs1_s, out_rs2_s;
    logic [2:0]  out_funct3_s;
    logic [1:0]  illegal_cnt_s;

    logic [EW-1:0] exp_q[$];
    int m_cnt = 0;
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    decode_ctrl_queue #(.ADDR_W(32), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
        .out_funct3(out_funct3), .illegal_cnt(illegal_cnt)
    );

    decode_ctrl_queue #(.ADDR_W(32), .DEPTH(DEPTH), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_s),
        .instr(instr), .pc(pc), .out_valid(out_valid_s), .out_ready(out_ready), .out_ctrl(out_ctrl_s),
        .out_pc(out_pc_s), .out_rd(out_rd_s), .out_rs1(out_rs1_s), .out_rs2(out_rs2_s),
        .out_funct3(out_funct3_s), .illegal_cnt(illegal_cnt_s)
    );

    // Reference decode written straight from the opcode table.
    function automatic ctrl_t mdec(input logic [31:0] ins);
        ctrl_t c;
        logic [2:0] f3;
        logic ill;
        c = '0;
        f3 = ins[14:12];
        ill = 1'b0;
        case (ins[6:0])
            7'b1101111: begin c.regWrite = 1; c.aluSrc = 1; c.immSrc = 3; c.resultSrc = 2; c.jumpSrc = 1; end
            7'b1100111: begin c.regWrite = 1; c.aluSrc = 1; c.immSrc = 0; c.resultSrc = 2; c.jumpSrc = 1; c.jalrSrc = 1; end
            7'b1100011: begin c.Branch = 1; c.immSrc = 2; c.aluOp = 1; end
            7'b0000011: begin
                if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) begin
                    c.regWrite = 1; c.aluSrc = 1; c.immSrc = 0; c.resultSrc = 1; c.sizeSrc = f3;
                end else ill = 1;
            end
            7'b0100011: begin
                if (f3 <= 2) begin c.memWrite = 1; c.aluSrc = 1; c.immSrc = 1; c.sizeSrc = f3; end
                else ill = 1;
            end
            7'b0010011: begin c.regWrite = 1; c.aluSrc = 1; c.immSrc = 0; c.aluOp = 2; end
            7'b0110011: begin c.regWrite = 1; c.aluOp = 2; end
            7'b0110111: begin c.regWrite = 1; c.aluSrc = 1; c.immSrc = 4; c.aluOp = 3; end
            7'b0010111: begin c.regWrite = 1; c.aluSrc = 1; c.aluSrcA_pc = 1; c.immSrc = 4; c.aluOp = 0; end
            default: ill = 1;
        endcase
        if (ill) begin c = '0; c.illegal = 1; end
        return c;
    endfunction

    function automatic logic [EW-1:0] mentry(input logic [31:0] ins, input logic [31:0] p);
        return {mdec(ins), p, ins[11:7], ins[19:15], ins[24:20], ins[14:12]};
    endfunction

    function automatic logic [EW-1:0] got();
        return {out_ctrl, out_pc, out_rd, out_rs1, out_rs2, out_funct3};
    endfunction

    function automatic int sat(input int lim);
        return (m_cnt > lim) ? lim : m_cnt;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [9];
        logic [31:0] r;
        int sel;
        opcs = '{7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011,
                 7'b0010011, 7'b0110011, 7'b0110111, 7'b0010111};
        r = $urandom();
        sel = $urandom_range(0, 11);
        if (sel < 9)  return {r[31:7], opcs[sel]};
        if (sel == 9) return r;
        return 32'hFFFF_FFFF;
    endfunction

    // Advance one clock, updating the model with what the edge should do.
    task automatic tick();
        logic acc, pp;
        acc = in_valid && !flush && (exp_q.size() < DEPTH);
        pp  = out_ready && !flush && (exp_q.size() != 0);
        if (flush) exp_q.delete();
        else begin
            if (pp) void'(exp_q.pop_front());
            if (acc) begin
                exp_q.push_back(mentry(instr, pc));
                if (mdec(instr).illegal) m_cnt++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 0; flush = 0; out_ready = 0;
        exp_q.delete();
        m_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_vec++; if (illegal_cnt !== 8'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", illegal_cnt); end
        do_reset();
    endtask

    task automatic test_load();
        in_valid = 1; instr = 32'h0080A283; pc = 32'h100; out_ready = 0;
        tick();
        in_valid = 0;
        #1;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lw_out_valid got %b want 1", out_valid); end
        n_vec++; if (out_ctrl.regWrite !== 1'b1 || out_ctrl.resultSrc !== 2'b01 || out_ctrl.sizeSrc !== 3'b010)
            begin n_err++; $display("FAIL lw_ctrl got %h want regWrite=1 resultSrc=01 sizeSrc=010", out_ctrl); end
        n_vec++; if (out_rd !== 5'd5 || out_rs1 !== 5'd1 || out_pc !== 32'h100)
            begin n_err++; $display("FAIL lw_fields got rd=%0d rs1=%0d pc=%h want 5 1 100", out_rd, out_rs1, out_pc); end
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    task automatic test_full_order();
        logic [31:0] ins [3];
        int sent;
        int cyc;
        for (int i = 0; i < 3; i++) ins[i] = rand_instr();
        sent = 0;
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; instr = ins[sent]; pc = 32'h200 + 4 * sent;
            #1;
            n_vec++; if (in_ready !== (i < 2)) begin n_err++; $display("FAIL full_in_ready cyc %0d got %b want %b", i, in_ready, i < 2); end
            if (i < 2) sent++;
            tick();
        end
        out_ready = 1;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_no_passthrough got %b want 0", in_ready); end
        cyc = 0;
        while ((sent < 3 || exp_q.size() != 0) && cyc < 20) begin
            in_valid = (sent < 3); instr = ins[sent > 2 ? 2 : sent]; pc = 32'h200 + 4 * sent;
            #1;
            n_vec++; if (in_ready !== (exp_q.size() < DEPTH)) begin n_err++; $display("FAIL drain_in_ready got %b want %b", in_ready, exp_q.size() < DEPTH); end
            n_vec++; if (got() !== exp_q[0]) begin n_err++; $display("FAIL drain_order got %h want %h", got(), exp_q[0]); end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        n_vec++; if (cyc >= 20) begin n_err++; $display("FAIL drain_timeout got %0d cycles want <20", cyc); end
        in_valid = 0; out_ready = 0;
    endtask

    task automatic test_illegal();
        do_reset();
        out_ready = 0;
        in_valid = 1; instr = 32'hFFFF_FFFF; pc = 32'h300;
        tick();
        instr = 32'h0080B283; pc = 32'h304;
        #1;
        n_vec++; if (out_ctrl.illegal !== 1'b1 || out_ctrl.regWrite !== 1'b0)
            begin n_err++; $display("FAIL illegal_ffff got %h want illegal=1 regWrite=0", out_ctrl); end
        tick();
        in_valid = 0; out_ready = 1;
        #1;
        n_vec++; if (illegal_cnt !== 8'd2) begin n_err++; $display("FAIL illegal_cnt got %0d want 2", illegal_cnt); end
        tick();
        #1;
        n_vec++; if (out_ctrl.illegal !== 1'b1 || out_ctrl.regWrite !== 1'b0 || out_pc !== 32'h304)
            begin n_err++; $display("FAIL illegal_lw011 got %h pc %h want illegal=1 regWrite=0 pc 304", out_ctrl, out_pc); end
        tick();
        out_ready = 0;
    endtask

    task automatic test_saturation();
        do_reset();
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            instr = 32'hFFFF_FFFF; pc = 32'h400 + 4 * i;
            tick();
        end
        in_valid = 0;
        #1;
        n_vec++; if (illegal_cnt_s !== 2'd3) begin n_err++; $display("FAIL sat_cnt got %0d want 3", illegal_cnt_s); end
        n_vec++; if (illegal_cnt !== 8'd5) begin n_err++; $display("FAIL wide_cnt got %0d want 5", illegal_cnt); end
        tick();
        out_ready = 0;
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 0; in_valid = 1;
        instr = 32'h0080A283; pc = 32'h500; tick();
        instr = 32'hFFFF_FFFF; pc = 32'h504; tick();
        flush = 1; out_ready = 1; instr = 32'hFFFF_FFFF; pc = 32'h508;
        #1;
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
        tick();
        flush = 0; in_valid = 0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got %b want 0", out_valid); end
        n_vec++; if (illegal_cnt !== 8'd1) begin n_err++; $display("FAIL flush_cnt got %0d want 1", illegal_cnt); end
        in_valid = 1; instr = 32'h00000013; pc = 32'h50C; out_ready = 0;
        tick();
        in_valid = 0;
        #1;
        n_vec++; if (out_valid !== 1'b1 || out_pc !== 32'h50C) begin n_err++; $display("FAIL post_flush got v=%b pc=%h want 1 50c", out_valid, out_pc); end
        out_ready = 1; tick(); out_ready = 0;
    endtask

    task automatic test_utype();
        out_ready = 0; in_valid = 1;
        instr = 32'h123451B7; pc = 32'h600; tick();
        instr = 32'h00001097; pc = 32'h604; tick();
        in_valid = 0; out_ready = 1;
        #1;
        n_vec++; if (out_ctrl.immSrc !== 3'b100 || out_ctrl.aluOp !== 2'b11 || out_ctrl.regWrite !== 1'b1 || out_rd !== 5'd3)
            begin n_err++; $display("FAIL lui got %h rd %0d want immSrc=100 aluOp=11 rd 3", out_ctrl, out_rd); end
        tick();
        #1;
        n_vec++; if (out_ctrl.immSrc !== 3'b100 || out_ctrl.aluOp !== 2'b00 || out_ctrl.aluSrcA_pc !== 1'b1)
            begin n_err++; $display("FAIL auipc got %h want immSrc=100 aluOp=00 aluSrcA_pc=1", out_ctrl); end
        tick();
        out_ready = 0;
    endtask

    task automatic test_reset_mid();
        out_ready = 0; in_valid = 1;
        instr = 32'hFFFF_FFFF; pc = 32'h700; tick();
        instr = 32'h00208033; pc = 32'h704; tick();
        in_valid = 0;
        #1;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_out_valid got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
        n_vec++; if (illegal_cnt !== 8'd0 || illegal_cnt_s !== 2'd0)
            begin n_err++; $display("FAIL midreset_cnt got %0d/%0d want 0/0", illegal_cnt, illegal_cnt_s); end
        do_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            instr     = rand_instr();
            pc        = $urandom();
            #1;
            n_vec++; if (in_ready !== (!flush && exp_q.size() < DEPTH))
                begin n_err++; $display("FAIL rnd_in_ready @%0d got %b want %b", i, in_ready, !flush && exp_q.size() < DEPTH); end
            n_vec++; if (out_valid !== (exp_q.size() != 0))
                begin n_err++; $display("FAIL rnd_out_valid @%0d got %b want %b", i, out_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                n_vec++; if (got() !== exp_q[0]) begin n_err++; $display("FAIL rnd_head @%0d got %h want %h", i, got(), exp_q[0]); end
            end
            n_vec++; if (illegal_cnt !== 8'(sat(255)) || illegal_cnt_s !== 2'(sat(3)))
                begin n_err++; $display("FAIL rnd_cnt @%0d got %0d/%0d want %0d/%0d", i, illegal_cnt, illegal_cnt_s, sat(255), sat(3)); end
            tick();
        end
        flush = 0; in_valid = 0; out_ready = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_load();
        test_full_order();
        test_illegal();
        test_saturation();
        test_flush();
        test_utype();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
